// File: rtl/sim_trace_pkg.sv
// rtl/sim_trace_pkg.sv - shared record type and width helpers for the commit-trace collector
package sim_trace_pkg;

   // Stored record field widths; the collector's ADDR_W/XLEN/SEQ_W must not exceed these.
   localparam int REC_ADDR_W = 32;
   localparam int REC_XLEN   = 64;
   localparam int REC_SEQ_W  = 16;
   localparam int DROP_W     = 16;

   typedef struct packed {
      logic [REC_ADDR_W-1:0] inst_addr;
      logic [31:0]           inst_hex;
      logic                  reg_wren;
      logic [4:0]            reg_wraddr;
      logic [REC_XLEN-1:0]   reg_wrdata;
      logic [REC_SEQ_W-1:0]  seq;
      logic                  lost;
   } trace_rec_t;

   function automatic int hid_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sim_trace_fifo.sv
// rtl/sim_trace_fifo.sv - single-clock FIFO of trace records
module sim_trace_fifo
   import sim_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  trace_rec_t push_data,
   input  logic       pop,
   output trace_rec_t pop_data,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   trace_rec_t  mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;

   // The extra pointer bit tells a full ring apart from an empty one.
   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop_data = mem[rptr[AW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/sim_trace_collector.sv
// rtl/sim_trace_collector.sv - per-hart retire capture, FIFO buffering and round-robin merge onto one trace stream
module sim_trace_collector
   import sim_trace_pkg::*;
#(
   parameter int NUM_HARTS = 2,
   parameter int XLEN      = 64,
   parameter int ADDR_W    = 32,
   parameter int DEPTH     = 8,
   parameter int SEQ_W     = 16,
   parameter bit PRINT_EN  = 1'b1,
   localparam int HID_W    = hid_w(NUM_HARTS)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        trace_en,
   input  logic [NUM_HARTS-1:0]        dbg_valid,
   input  logic [NUM_HARTS*ADDR_W-1:0] dbg_inst_addr,
   input  logic [NUM_HARTS*32-1:0]     dbg_inst_hex,
   input  logic [NUM_HARTS-1:0]        dbg_reg_wren,
   input  logic [NUM_HARTS*5-1:0]      dbg_reg_wraddr,
   input  logic [NUM_HARTS*XLEN-1:0]   dbg_reg_wrdata,
   output logic                        trc_valid,
   input  logic                        trc_ready,
   output logic [HID_W-1:0]            trc_hart_id,
   output logic [SEQ_W-1:0]            trc_seq,
   output logic                        trc_lost,
   output logic [ADDR_W-1:0]           trc_inst_addr,
   output logic [31:0]                 trc_inst_hex,
   output logic                        trc_reg_wren,
   output logic [4:0]                  trc_reg_wraddr,
   output logic [XLEN-1:0]             trc_reg_wrdata,
   output logic [NUM_HARTS*16-1:0]     drop_cnt
);

   trace_rec_t           head_rec [NUM_HARTS];
   trace_rec_t           out_rec;
   logic [NUM_HARTS-1:0] sample;
   logic [NUM_HARTS-1:0] push;
   logic [NUM_HARTS-1:0] pop;
   logic [NUM_HARTS-1:0] full;
   logic [NUM_HARTS-1:0] empty;
   logic [HID_W-1:0]     rr_q;
   logic [HID_W-1:0]     winner;
   logic                 found;
   logic                 load;

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      logic [SEQ_W-1:0]  seq_q;
      logic [DROP_W-1:0] drop_q;
      logic              lost_q;
      trace_rec_t        rec_in;

      assign sample[h] = dbg_valid[h] & trace_en;
      assign pop[h]    = load & found & (winner == HID_W'(h));
      // A full FIFO still takes the record when its head leaves this same cycle.
      assign push[h]   = sample[h] & (~full[h] | pop[h]);

      assign rec_in = '{inst_addr:  REC_ADDR_W'(dbg_inst_addr[h*ADDR_W +: ADDR_W]),
                        inst_hex:   dbg_inst_hex[h*32 +: 32],
                        reg_wren:   dbg_reg_wren[h],
                        reg_wraddr: dbg_reg_wraddr[h*5 +: 5],
                        reg_wrdata: REC_XLEN'(dbg_reg_wrdata[h*XLEN +: XLEN]),
                        seq:        REC_SEQ_W'(seq_q),
                        lost:       lost_q};

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            seq_q  <= '0;
            drop_q <= '0;
            lost_q <= 1'b0;
         end else if (sample[h]) begin
            seq_q <= seq_q + SEQ_W'(1);
            if (push[h]) begin
               lost_q <= 1'b0;
            end else begin
               lost_q <= 1'b1;
               if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
            end
         end
      end

      assign drop_cnt[h*DROP_W +: DROP_W] = drop_q;

      sim_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clock     (clock),
         .reset     (reset),
         .push      (push[h]),
         .push_data (rec_in),
         .pop       (pop[h]),
         .pop_data  (head_rec[h]),
         .full      (full[h]),
         .empty     (empty[h])
      );
   end

   assign load = ~trc_valid | trc_ready;

   // First non-empty hart at or after the round-robin pointer, wrapping.
   always_comb begin
      int idx;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < NUM_HARTS; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_HARTS) idx = idx - NUM_HARTS;
         if (!found && !empty[idx]) begin
            found  = 1'b1;
            winner = idx[HID_W-1:0];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         trc_valid   <= 1'b0;
         trc_hart_id <= '0;
         out_rec     <= '0;
         rr_q        <= '0;
      end else if (load) begin
         trc_valid <= found;
         if (found) begin
            out_rec     <= head_rec[winner];
            trc_hart_id <= winner;
            rr_q        <= (winner == HID_W'(NUM_HARTS-1)) ? '0 : winner + HID_W'(1);
         end
      end
   end

   assign trc_seq        = out_rec.seq[SEQ_W-1:0];
   assign trc_lost       = out_rec.lost;
   assign trc_inst_addr  = out_rec.inst_addr[ADDR_W-1:0];
   assign trc_inst_hex   = out_rec.inst_hex;
   assign trc_reg_wren   = out_rec.reg_wren;
   assign trc_reg_wraddr = out_rec.reg_wraddr;
   assign trc_reg_wrdata = out_rec.reg_wrdata[XLEN-1:0];

`ifndef SYNTHESIS
   if (PRINT_EN) begin : g_printer
      always @(posedge clock) begin
         if (!reset && trc_valid && trc_ready) begin
            if (trc_lost)
               $write("%t HART%0d #%0d [L] %h:%h", $time, trc_hart_id, trc_seq, trc_inst_addr, trc_inst_hex);
            else
               $write("%t HART%0d #%0d %h:%h", $time, trc_hart_id, trc_seq, trc_inst_addr, trc_inst_hex);
            if (trc_reg_wren)
               $write(" R%02d<=%h\n", trc_reg_wraddr, trc_reg_wrdata);
            else
               $write("%s\n", {(6 + XLEN/4){" "}});
         end
      end
   end
`endif

endmodule

// File: tb/tb_sim_trace_collector.sv
// tb/tb_sim_trace_collector.sv - scoreboard bench for the commit-trace collector
module tb_sim_trace_collector;

   localparam int N      = 2;
   localparam int XLEN   = 64;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 8;
   localparam int SEQ_W  = 16;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  trace_en;
   logic [N-1:0]          dbg_valid;
   logic [N*ADDR_W-1:0]   dbg_inst_addr;
   logic [N*32-1:0]       dbg_inst_hex;
   logic [N-1:0]          dbg_reg_wren;
   logic [N*5-1:0]        dbg_reg_wraddr;
   logic [N*XLEN-1:0]     dbg_reg_wrdata;
   logic                  trc_valid;
   logic                  trc_ready;
   logic [0:0]            trc_hart_id;
   logic [SEQ_W-1:0]      trc_seq;
   logic                  trc_lost;
   logic [ADDR_W-1:0]     trc_inst_addr;
   logic [31:0]           trc_inst_hex;
   logic                  trc_reg_wren;
   logic [4:0]            trc_reg_wraddr;
   logic [XLEN-1:0]       trc_reg_wrdata;
   logic [N*16-1:0]       drop_cnt;

   sim_trace_collector #(
      .NUM_HARTS(N), .XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W), .PRINT_EN(1'b0)
   ) dut (
      .clock(clock), .reset(reset), .trace_en(trace_en),
      .dbg_valid(dbg_valid), .dbg_inst_addr(dbg_inst_addr), .dbg_inst_hex(dbg_inst_hex),
      .dbg_reg_wren(dbg_reg_wren), .dbg_reg_wraddr(dbg_reg_wraddr), .dbg_reg_wrdata(dbg_reg_wrdata),
      .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_hart_id(trc_hart_id), .trc_seq(trc_seq),
      .trc_lost(trc_lost), .trc_inst_addr(trc_inst_addr), .trc_inst_hex(trc_inst_hex),
      .trc_reg_wren(trc_reg_wren), .trc_reg_wraddr(trc_reg_wraddr), .trc_reg_wrdata(trc_reg_wrdata),
      .drop_cnt(drop_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          hart;
      int          seq;
      bit          lost;
      logic [31:0] addr;
      logic [31:0] hex;
      bit          wren;
      logic [4:0]  wa;
      logic [63:0] wd;
   } rec_t;

   // Reference model: per-hart queues, one output slot, round-robin pointer.
   rec_t m_q [N][$];
   rec_t sb [$];
   int   m_seq [N];
   bit   m_lost [N];
   int   m_drop [N];
   bit   m_valid;
   int   m_rr;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int h = 0; h < N; h++) begin
         m_q[h].delete();
         m_seq[h]  = 0;
         m_lost[h] = 0;
         m_drop[h] = 0;
      end
      sb.delete();
      m_valid = 0;
      m_rr    = 0;
   endtask

   task automatic model_step();
      int   w;
      rec_t r;
      if (!m_valid || trc_ready) begin
         w = -1;
         for (int i = 0; i < N; i++) begin
            int h = (m_rr + i) % N;
            if (w < 0 && m_q[h].size() > 0) w = h;
         end
         if (w >= 0) begin
            r = m_q[w].pop_front();
            sb.push_back(r);
            m_valid = 1;
            m_rr    = (w + 1) % N;
         end else begin
            m_valid = 0;
         end
      end
      if (trace_en) begin
         for (int h = 0; h < N; h++) begin
            if (dbg_valid[h]) begin
               r.hart = h;
               r.seq  = m_seq[h];
               r.addr = dbg_inst_addr[h*ADDR_W +: ADDR_W];
               r.hex  = dbg_inst_hex[h*32 +: 32];
               r.wren = dbg_reg_wren[h];
               r.wa   = dbg_reg_wraddr[h*5 +: 5];
               r.wd   = dbg_reg_wrdata[h*XLEN +: XLEN];
               m_seq[h] = (m_seq[h] + 1) % 65536;
               if (m_q[h].size() < DEPTH) begin
                  r.lost    = m_lost[h];
                  m_lost[h] = 0;
                  m_q[h].push_back(r);
               end else begin
                  m_lost[h] = 1;
                  if (m_drop[h] < 65535) m_drop[h]++;
               end
            end
         end
      end
   endtask

   task automatic set_rec(input int h, input bit v);
      dbg_valid[h]                   = v;
      dbg_inst_addr[h*ADDR_W +: ADDR_W] = $urandom;
      dbg_inst_hex[h*32 +: 32]       = $urandom;
      dbg_reg_wren[h]                = 1'($urandom);
      dbg_reg_wraddr[h*5 +: 5]       = 5'($urandom);
      dbg_reg_wrdata[h*XLEN +: XLEN] = {$urandom, $urandom};
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
   endtask

   function automatic logic [151:0] snap();
      return {trc_hart_id, trc_seq, trc_lost, trc_inst_addr, trc_inst_hex,
              trc_reg_wren, trc_reg_wraddr, trc_reg_wrdata};
   endfunction

   // Monitor: checks valid against the model, stall stability, and pops the scoreboard on each handshake.
   rec_t         mr;
   bit           stalled = 0;
   logic [151:0] held;
   always @(negedge clock) begin
      if (reset) begin
         stalled = 0;
      end else begin
         chk("valid", trc_valid, m_valid);
         if (stalled && trc_valid) chk("stall_hold", snap(), held);
         if (trc_valid && trc_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               mr = sb.pop_front();
               chk("hart",   trc_hart_id, mr.hart);
               chk("seq",    trc_seq, mr.seq);
               chk("lost",   trc_lost, mr.lost);
               chk("addr",   trc_inst_addr, mr.addr);
               chk("hex",    trc_inst_hex, mr.hex);
               chk("wren",   trc_reg_wren, mr.wren);
               chk("wraddr", trc_reg_wraddr, mr.wa);
               chk("wrdata", trc_reg_wrdata, mr.wd);
            end
         end
         stalled = trc_valid && !trc_ready;
         held    = snap();
      end
   end

   task automatic idle(input int n);
      dbg_valid = '0;
      repeat (n) step();
   endtask

   task automatic chk_drops(input string nm);
      for (int h = 0; h < N; h++) chk(nm, drop_cnt[h*16 +: 16], m_drop[h]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; trace_en = 0; trc_ready = 0;
      dbg_valid = '0; dbg_inst_addr = '0; dbg_inst_hex = '0;
      dbg_reg_wren = '0; dbg_reg_wraddr = '0; dbg_reg_wrdata = '0;
      model_reset();
      repeat (3) @(posedge clock);
      #1 reset = 0;

      chk("rst_valid", trc_valid, 0);
      chk("rst_drop",  drop_cnt, 0);
      chk("rst_seq",   trc_seq, 0);
      chk("rst_addr",  trc_inst_addr, 0);

      // Single hart, three sequential PCs, first-output latency.
      trace_en = 1; trc_ready = 1;
      for (int i = 0; i < 3; i++) begin
         set_rec(0, 1);
         dbg_inst_addr[0 +: 32] = 32'h8000_0000 + 32'(4*i);
         step();
         if (i == 0) chk("latency_k", trc_valid, 0);
         if (i == 1) chk("latency_k1", trc_valid, 1);
      end
      idle(4);

      // Both harts every cycle: alternating output.
      for (int i = 0; i < 4; i++) begin
         set_rec(0, 1); set_rec(1, 1);
         step();
      end
      idle(10);
      chk_drops("drop_two_hart");

      // Overflow under backpressure, then full FIFO with simultaneous push and pop.
      trc_ready = 0;
      for (int i = 0; i < 10; i++) begin
         set_rec(0, 1);
         step();
      end
      dbg_valid = '0;
      chk("drop_overflow", drop_cnt[15:0], m_drop[0]);
      trc_ready = 1;
      for (int i = 0; i < 3; i++) begin
         set_rec(0, 1);
         step();
      end
      chk("drop_full_pushpop", drop_cnt[15:0], m_drop[0]);
      idle(14);

      // Toggling ready with random traffic.
      for (int i = 0; i < 60; i++) begin
         trc_ready = ~trc_ready;
         set_rec(0, 1'($urandom)); set_rec(1, 1'($urandom));
         step();
      end
      trc_ready = 1;
      idle(20);
      chk_drops("drop_toggle");

      // Reset with records buffered.
      trc_ready = 0;
      for (int i = 0; i < 5; i++) begin
         set_rec(1, 1);
         step();
      end
      dbg_valid = '0;
      #2 reset = 1;
      #1;
      chk("rst_mid_valid", trc_valid, 0);
      chk("rst_mid_drop",  drop_cnt, 0);
      model_reset();
      @(posedge clock);
      #1 reset = 0;
      trc_ready = 1;
      set_rec(1, 1);
      step();
      idle(4);

      // Long random run, including trace_en off periods.
      for (int i = 0; i < 400; i++) begin
         trace_en  = ($urandom_range(0, 9) != 0);
         trc_ready = ($urandom_range(0, 9) < 6);
         set_rec(0, 1'($urandom)); set_rec(1, 1'($urandom));
         step();
      end
      trc_ready = 1;
      idle(2*DEPTH + 10);
      chk_drops("drop_random");
      chk("sb_drained", sb.size(), 0);
      chk("end_valid", trc_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
